// File: rtl/ccff_loader_pkg.sv
// Shared types and width helpers for the ccff bitstream loader.
//   ccff_state_e : loader pass state (IDLE -> SHIFT -> DONE -> IDLE)
//   cnt_w()      : bit-counter width, able to hold 0..CHAIN_LEN
//   sr_cnt_w()   : serializer valid-bit count width, able to hold 0..WORD_W
// The widths depend on module parameters, so they are provided as functions
// and turned into CNT_W / SR_CNT_W localparams by the modules that use them.
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } ccff_state_e;

  function automatic int cnt_w(input int chain_len);
    return $clog2(chain_len + 1);
  endfunction

  function automatic int sr_cnt_w(input int word_w);
    return $clog2(word_w + 1);
  endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// Two-stage word serializer: holding register (HR) in front of a shift
// register (SR). Words enter HR (or go straight to SR when SR is free) and
// leave MSB-first, one bit per shift-enabled cycle.
//   clk, rst   : clock, synchronous active-high reset
//   en         : pass active; when low both stages are flushed
//   in_data    : host word, bit WORD_W-1 leaves first
//   in_valid   : host word valid
//   in_ready   : HR empty (and enabled)
//   head       : SR MSB, serial output
//   shift_en   : SR holds at least one valid bit
module ccff_word_serializer
  import ccff_loader_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              head,
  output logic              shift_en
);

  localparam int SR_CNT_W = sr_cnt_w(WORD_W);
  localparam logic [SR_CNT_W-1:0] SR_FULL = SR_CNT_W'(WORD_W);
  localparam logic [SR_CNT_W-1:0] SR_ONE  = SR_CNT_W'(1);

  logic [WORD_W-1:0]   sr_q, hr_q;
  logic [SR_CNT_W-1:0] sr_cnt_q;
  logic                hr_vld_q;
  logic                accept, sr_free;

  assign shift_en = en && (sr_cnt_q != '0);
  assign in_ready = en && !hr_vld_q;
  assign head     = sr_q[WORD_W-1];
  assign accept   = in_valid && in_ready;
  // SR can take a new word this edge: already empty, or draining its last bit.
  assign sr_free  = (sr_cnt_q == '0) || (shift_en && sr_cnt_q == SR_ONE);

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      // Data is cleared too so the head idles low between passes.
      sr_q     <= '0;
      hr_q     <= '0;
      sr_cnt_q <= '0;
      hr_vld_q <= 1'b0;
    end else if (sr_free && hr_vld_q) begin
      // in_ready is low here, so no accept can collide with the HR move.
      sr_q     <= hr_q;
      sr_cnt_q <= SR_FULL;
      hr_vld_q <= 1'b0;
    end else if (sr_free && accept) begin
      // Bypass HR so the first word (or a word after a stall) has no bubble.
      sr_q     <= in_data;
      sr_cnt_q <= SR_FULL;
    end else begin
      if (shift_en) begin
        sr_q     <= sr_q << 1;
        sr_cnt_q <= sr_cnt_q - SR_ONE;
      end
      if (accept) begin
        hr_q     <= in_data;
        hr_vld_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Configuration-chain loader. Serializes host words MSB-first onto ccff_head,
// gating the chain clock so host stalls never inject bits, and on verify
// passes compares the returning ccff_tail against the bit being shifted in.
//   prog_clk, pReset : clock, synchronous active-high reset
//   start, verify    : begin a pass (IDLE only); 0 = load, 1 = verify
//   word_data/valid/ready : host word handshake
//   ccff_head, ccff_shift_en, ccff_tail : chain serial in, clock enable, serial out
//   config_enable, busy, done : pass status; done pulses one cycle at the end
//   err_cnt          : saturating mismatch count of the last verify pass
module ccff_bitstream_loader
  import ccff_loader_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int CHAIN_LEN = 1024,
  parameter int ERR_W     = 16
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              verify,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              config_enable,
  output logic              busy,
  output logic              done,
  output logic [ERR_W-1:0]  err_cnt
);

  localparam int CNT_W = cnt_w(CHAIN_LEN);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

  ccff_state_e      state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q;
  logic             verify_q;
  logic [ERR_W-1:0] err_cnt_q;
  logic             ser_en, last_shift;

  assign ser_en     = (state_q == ST_SHIFT);
  assign last_shift = ccff_shift_en && (bit_cnt_q == LAST_BIT);
  assign err_cnt    = err_cnt_q;

  ccff_word_serializer #(.WORD_W(WORD_W)) u_ser (
    .clk      (prog_clk),
    .rst      (pReset),
    .en       (ser_en),
    .in_data  (word_data),
    .in_valid (word_valid),
    .in_ready (word_ready),
    .head     (ccff_head),
    .shift_en (ccff_shift_en)
  );

  always_comb begin
    state_d       = state_q;
    busy          = 1'b1;
    config_enable = 1'b1;
    done          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy          = 1'b0;
        config_enable = 1'b0;
        if (start) state_d = ST_SHIFT;
      end
      ST_SHIFT: if (last_shift) state_d = ST_DONE;
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      verify_q  <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && start) begin
        bit_cnt_q <= '0;
        verify_q  <= verify;
        if (verify) err_cnt_q <= '0;
      end else if (ccff_shift_en) begin
        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
        // Tail still shows the pre-edge value, i.e. the previous pass's bit k.
        if (verify_q && (ccff_tail != ccff_head) && (err_cnt_q != ERR_MAX))
          err_cnt_q <= err_cnt_q + ERR_W'(1);
      end
    end
  end

endmodule
